// File: rtl/che_pkg.sv
// Shared definitions for the contrast histogram equalisation pipeline.
package che_pkg;

  typedef enum logic [1:0] {
    CHE_CDF_ST_IDLE  = 2'd0,
    CHE_CDF_ST_READ  = 2'd1,
    CHE_CDF_ST_DRAIN = 2'd2,
    CHE_CDF_ST_DONE  = 2'd3
  } che_cdf_st_e;

  function automatic int unsigned che_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/che_cdf_ctrl_if.sv
// Histogram RAM read/clear port and CDF RAM write port of the CDF sequencer.
interface che_cdf_ctrl_if #(
  parameter int unsigned ADR_WD = 8,
  parameter int unsigned BIN_WD = 16,
  parameter int unsigned CDF_WD = 24
);

  logic              hist_rd_en_o;
  logic [ADR_WD-1:0] hist_rd_adr_o;
  logic [BIN_WD-1:0] hist_rd_dat_i;
  logic              hist_wr_en_o;
  logic [ADR_WD-1:0] hist_wr_adr_o;
  logic [BIN_WD-1:0] hist_wr_dat_o;
  logic              cdf_wr_en_o;
  logic [ADR_WD-1:0] cdf_wr_adr_o;
  logic [CDF_WD-1:0] cdf_wr_dat_o;

  modport master (
    output hist_rd_en_o, hist_rd_adr_o,
    input  hist_rd_dat_i,
    output hist_wr_en_o, hist_wr_adr_o, hist_wr_dat_o,
    output cdf_wr_en_o, cdf_wr_adr_o, cdf_wr_dat_o
  );

  modport slave (
    input  hist_rd_en_o, hist_rd_adr_o,
    output hist_rd_dat_i,
    input  hist_wr_en_o, hist_wr_adr_o, hist_wr_dat_o,
    input  cdf_wr_en_o, cdf_wr_adr_o, cdf_wr_dat_o
  );

endinterface

// File: rtl/che_cdf_acc.sv
// Saturating cumulative-sum accumulator with overflow flag and first-non-zero capture.
module che_cdf_acc
  import che_pkg::*;
#(
  parameter int unsigned BIN_WD = 16,
  parameter int unsigned CDF_WD = 24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              vld,
  input  logic [BIN_WD-1:0] dat,
  output logic [CDF_WD-1:0] acc,
  output logic [CDF_WD-1:0] min,
  output logic              ovf
);

  localparam int unsigned PadWd = CDF_WD + 1 - BIN_WD;

  logic [CDF_WD:0]   sum;
  logic [CDF_WD-1:0] acc_q, acc_d, min_q, min_d;
  logic              ovf_q, ovf_d, got_q, got_d;

  always_comb begin
    sum   = {1'b0, acc_q} + {{PadWd{1'b0}}, dat};
    acc_d = acc_q;
    min_d = min_q;
    ovf_d = ovf_q;
    got_d = got_q;
    if (clr) begin
      acc_d = '0;
      min_d = '0;
      ovf_d = 1'b0;
      got_d = 1'b0;
    end else if (vld) begin
      acc_d = sum[CDF_WD] ? '1 : sum[CDF_WD-1:0];
      ovf_d = ovf_q | sum[CDF_WD];
      // min is the CDF value of the first bin that makes the running sum non-zero
      if (!got_q && (acc_d != '0)) begin
        got_d = 1'b1;
        min_d = acc_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      min_q <= '0;
      ovf_q <= 1'b0;
      got_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      min_q <= min_d;
      ovf_q <= ovf_d;
      got_q <= got_d;
    end
  end

  assign acc = acc_q;
  assign min = min_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/che_cdf_ctrl.sv
// CDF stage sequencer: sweeps and clears the histogram RAM, writes the CDF RAM and
// reports total count and first non-zero CDF value of the completed sweep.
module che_cdf_ctrl
  import che_pkg::*;
#(
  parameter int unsigned BIN_NUM = 256,
  parameter int unsigned BIN_WD  = 16,
  parameter int unsigned ADR_WD  = che_clog2(BIN_NUM),
  parameter int unsigned CDF_WD  = BIN_WD + ADR_WD
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CDF_WD-1:0] cdf_min_o,
  output logic [CDF_WD-1:0] cdf_tot_o,
  output logic              cdf_ovf_o,
  che_cdf_ctrl_if.master    bus
);

  localparam logic [ADR_WD-1:0] LastAdr = ADR_WD'(BIN_NUM - 1);

  che_cdf_st_e       st_q, st_d;
  logic [ADR_WD-1:0] adr_q, adr_d;
  logic              rd_vld_q, wr_vld_q;
  logic [ADR_WD-1:0] rd_adr_q, wr_adr_q;
  logic [CDF_WD-1:0] res_min_q, res_tot_q;
  logic              res_ovf_q;
  logic              go, last_wr, fin, rd_en;
  logic [CDF_WD-1:0] acc, acc_min;
  logic              acc_ovf;

  assign rd_en   = (st_q == CHE_CDF_ST_READ);
  assign go      = (st_q == CHE_CDF_ST_IDLE) && start_i && !abort_i;
  assign last_wr = wr_vld_q && (wr_adr_q == LastAdr);
  assign fin     = (st_q == CHE_CDF_ST_DRAIN) && last_wr && !abort_i;

  always_comb begin
    st_d  = st_q;
    adr_d = adr_q;
    case (st_q)
      CHE_CDF_ST_IDLE: begin
        if (go) begin
          st_d  = CHE_CDF_ST_READ;
          adr_d = '0;
        end
      end
      CHE_CDF_ST_READ: begin
        if (adr_q == LastAdr) st_d = CHE_CDF_ST_DRAIN;
        else                  adr_d = adr_q + 1'b1;
      end
      CHE_CDF_ST_DRAIN: begin
        if (last_wr) st_d = CHE_CDF_ST_DONE;
      end
      CHE_CDF_ST_DONE: st_d = CHE_CDF_ST_IDLE;
      default:         st_d = CHE_CDF_ST_IDLE;
    endcase
    if (abort_i) st_d = CHE_CDF_ST_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q  <= CHE_CDF_ST_IDLE;
      adr_q <= '0;
    end else begin
      st_q  <= st_d;
      adr_q <= adr_d;
    end
  end

  // Read -> data return/clear -> CDF write; abort kills the in-flight stages at once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld_q <= 1'b0;
      rd_adr_q <= '0;
      wr_vld_q <= 1'b0;
      wr_adr_q <= '0;
    end else begin
      rd_vld_q <= rd_en & ~abort_i;
      rd_adr_q <= adr_q;
      wr_vld_q <= rd_vld_q & ~abort_i;
      wr_adr_q <= rd_adr_q;
    end
  end

  che_cdf_acc #(
    .BIN_WD (BIN_WD),
    .CDF_WD (CDF_WD)
  ) u_acc (
    .clk  (clk),
    .rstn (rstn),
    .clr  (go),
    .vld  (rd_vld_q),
    .dat  (bus.hist_rd_dat_i),
    .acc  (acc),
    .min  (acc_min),
    .ovf  (acc_ovf)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_min_q <= '0;
      res_tot_q <= '0;
      res_ovf_q <= 1'b0;
    end else if (fin) begin
      res_min_q <= acc_min;
      res_tot_q <= acc;
      res_ovf_q <= acc_ovf;
    end
  end

  assign busy_o    = (st_q != CHE_CDF_ST_IDLE);
  assign done_o    = (st_q == CHE_CDF_ST_DONE);
  assign cdf_min_o = res_min_q;
  assign cdf_tot_o = res_tot_q;
  assign cdf_ovf_o = res_ovf_q;

  assign bus.hist_rd_en_o  = rd_en;
  assign bus.hist_rd_adr_o = adr_q;
  assign bus.hist_wr_en_o  = rd_vld_q;
  assign bus.hist_wr_adr_o = rd_adr_q;
  assign bus.hist_wr_dat_o = '0;
  assign bus.cdf_wr_en_o   = wr_vld_q;
  assign bus.cdf_wr_adr_o  = wr_adr_q;
  assign bus.cdf_wr_dat_o  = acc;

endmodule

// File: doc/che_cdf_ctrl.md
# che_cdf_ctrl

Sequencer for the CDF stage of the contrast histogram equalisation (CHE) pipeline. After a frame's histogram is complete, it sweeps the histogram RAM one bin per cycle and clears each bin for the next frame. It accumulates a running cumulative sum and writes one CDF entry per bin into the CDF RAM. It reports the total pixel count and `cdf_min` (the first non-zero CDF value) to the downstream mapping-LUT stage.

## Interface
Parameters:
- BIN_NUM, 256, number of histogram bins; power of two, ≥ 4.
- BIN_WD, 16, width of one histogram bin count.
- ADR_WD, clog2(BIN_NUM), bin address width (derived).
- CDF_WD, BIN_WD + ADR_WD, width of CDF entries, accumulator, `cdf_min` and `cdf_tot` (derived).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle pulse; begins a sweep; ignored unless in IDLE.
- abort_i  in  1  synchronous abort; forces IDLE.
- busy_o  out  1  high in every state other than IDLE.
- done_o  out  1  single-cycle pulse when the sweep completes.
- hist_rd_en_o  out  1  histogram read strobe.
- hist_rd_adr_o  out  ADR_WD  histogram read address.
- hist_rd_dat_i  in  BIN_WD  read data; valid exactly 1 cycle after `hist_rd_en_o`.
- hist_wr_en_o  out  1  histogram clear strobe.
- hist_wr_adr_o  out  ADR_WD  histogram clear address.
- hist_wr_dat_o  out  BIN_WD  always 0.
- cdf_wr_en_o  out  1  CDF RAM write strobe.
- cdf_wr_adr_o  out  ADR_WD  CDF RAM write address.
- cdf_wr_dat_o  out  CDF_WD  cumulative count through this bin.
- cdf_min_o  out  CDF_WD  first non-zero CDF value of the last completed sweep.
- cdf_tot_o  out  CDF_WD  final CDF value (total count) of the last completed sweep.
- cdf_ovf_o  out  1  sticky; accumulator saturated during the last sweep.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE → READ on `start_i`.
  - READ → DRAIN after issuing address BIN_NUM-1.
  - DRAIN → DONE once the last CDF write is issued.
  - DONE → IDLE unconditionally.
  - `abort_i` takes any state → IDLE on the next edge and has priority over `start_i`.
- READ:
  - `hist_rd_en_o` = 1.
  - The address counter runs 0..BIN_NUM-1 and increments by 1 per cycle. No wrap: the FSM leaves READ at the terminal count.
- Data-return cycle, i.e. the cycle after each read:
  - `hist_wr_en_o` = 1 and `hist_wr_adr_o` = that bin, writing 0 (read-then-clear).
  - Accumulator `acc <= acc + hist_rd_dat_i` (zero-extended).
- CDF write:
  - Registered; issued the cycle after data return.
  - `cdf_wr_adr_o` = bin index; `cdf_wr_dat_o` = acc including that bin.
- Saturation:
  - If the sum exceeds 2^CDF_WD − 1, acc holds all-ones and `cdf_ovf_o` is set.
  - This is unreachable at the defaults and is present for parameter safety.
- `cdf_min` tracking:
  - Captured on the first CDF write with non-zero data.
  - If every bin is zero, `cdf_min_o` = 0.
- Clearing at `start_i`: acc, the min-captured flag and `cdf_ovf_o` are cleared.
- Holding: `cdf_min_o`, `cdf_tot_o` and `cdf_ovf_o` update at DONE and hold until the next DONE.
- Abort:
  - No `done_o`; strobes drop on the next cycle.
  - Result outputs keep their previous sweep values.
  - The histogram is left partially cleared; software must re-run the sweep.

## Timing
- Reset values: all outputs 0; FSM in IDLE.
- Cycle numbering: `start_i` sampled high at edge E0.
- Reads: `hist_rd_en_o` is high in cycles 1..BIN_NUM, with address k in cycle k+1.
- Returns and clears: read data and the clear of bin k occur in cycle k+2.
- CDF writes: bin k is written in cycle k+3, covering cycles 3..BIN_NUM+2.
- Completion: `done_o` is high in cycle BIN_NUM+3, and results are valid from that same cycle.
- Total latency from start to `done_o` is BIN_NUM+3 cycles. The block is back in IDLE in cycle BIN_NUM+4, where a new `start_i` is accepted.
- `start_i` while busy is dropped and has no effect.
- Simultaneous `start_i` and `abort_i` in IDLE: stay in IDLE.
- Reset asserted mid-sweep: all outputs go to 0 immediately (asynchronous).

## Structure
- Shared package `che_pkg`: FSM state encoding `CHE_CDF_ST_*` and the clog2 constant function used to derive ADR_WD.
- Sub-module `che_cdf_acc`: saturating accumulator, ovf flag and first-non-zero capture. Inputs: clr, vld, dat. Outputs: acc, min, ovf.
- Top level holds the FSM, address counter and the read/clear/write strobe pipeline.

## Test plan
- Histogram RAM model with 1-cycle read latency, BIN_NUM=16, bins all 1; start → CDF writes 1,2,…,16 at addresses 0..15 in cycles 3..18; `done_o` in cycle 19; `cdf_min_o`=1; `cdf_tot_o`=16; all bins read back as 0 afterwards.
- Bins 0..4 = 0, bin 5 = 7, bin 15 = 3, others 0 → `cdf_min_o`=7, `cdf_tot_o`=10, CDF entries 0..4 = 0.
- All bins 0 → `cdf_min_o`=0, `cdf_tot_o`=0, `cdf_ovf_o`=0.
- BIN_WD=4, CDF_WD forced to 4, bins all 15 → acc saturates at 15; `cdf_ovf_o`=1 at DONE.
- `abort_i` in cycle 6 → all strobes low from cycle 7; no `done_o`; previous results unchanged. A second `start_i` during a sweep is ignored, and that sweep's timing is unchanged.
- `rstn` low in cycle 10 → all outputs 0 at once; after release, a new start runs a full sweep correctly.
